// File: rtl/apb_rr_master.sv
// apb_rr_master
//   Round-robin APB master scheduler. NUM_REQ request/response clients share
//   one 32-bit APB bus, with exactly one transfer in flight at a time. Each
//   ACCESS phase is guarded by a pready timeout watchdog.
//
// Handshake:
//   In IDLE, the winning requester sees req_ready high combinationally in the
//   same cycle as its req_valid. Its write, addr and wdata fields are captured
//   on that clock edge only. The requester may change them freely afterwards.
//   rsp_valid is a one-cycle pulse to the owner and has no backpressure.
//   rsp_rdata and rsp_err are meaningful only while rsp_valid is high.
//
// Ports:
//   clk, rst               rising-edge clock, async active-high reset
//   req_valid/ready        per-requester request / one-hot grant
//   req_write/addr/wdata   packed per-requester transfer fields
//   rsp_valid/rdata/err    one-hot completion pulse, shared read data, error
//   psel/penable/pwrite    APB control
//   paddr/pwdata/prdata    APB address and data
//   pready/pslverr         APB completion and error
//   dbg_state_o            current FSM state (0 idle, 1 setup, 2 access)
module apb_rr_master #(
   parameter int NUM_REQ        = 3,
   parameter int APB_ADDR_WIDTH = 12,
   parameter int TIMEOUT        = 256
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_REQ-1:0]                req_valid,
   output logic [NUM_REQ-1:0]                req_ready,
   input  logic [NUM_REQ-1:0]                req_write,
   input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*32-1:0]             req_wdata,
   output logic [NUM_REQ-1:0]                rsp_valid,
   output logic [31:0]                       rsp_rdata,
   output logic                              rsp_err,
   output logic                              psel,
   output logic                              penable,
   output logic                              pwrite,
   output logic [APB_ADDR_WIDTH-1:0]         paddr,
   output logic [31:0]                       pwdata,
   input  logic [31:0]                       prdata,
   input  logic                              pready,
   input  logic                              pslverr,
   output logic [1:0]                        dbg_state_o
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic [CNT_W-1:0] TO_LAST_C = CNT_W'(TO_LAST);
   localparam logic [IDX_W:0]   NREQ_C    = (IDX_W+1)'(NUM_REQ);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2
   } state_t;

   state_t                    state_q;
   logic [IDX_W-1:0]          ptr_q;      // last winner, also owner of the transfer in flight
   logic [CNT_W-1:0]          cnt_q;
   logic                      psel_q;
   logic                      penable_q;
   logic                      pwrite_q;
   logic [APB_ADDR_WIDTH-1:0] paddr_q;
   logic [31:0]               pwdata_q;
   logic [NUM_REQ-1:0]        rsp_valid_q;
   logic [31:0]               rsp_rdata_q;
   logic                      rsp_err_q;

   logic                      win_found;
   logic [IDX_W-1:0]          win_idx;
   logic [IDX_W:0]            cand;

   // Round-robin scan upward from ptr+1. The candidate is one bit wider than
   // the index so that ptr+i cannot overflow before the modulo fold.
   always_comb begin
      win_found = 1'b0;
      win_idx   = ptr_q;
      cand      = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = {1'b0, ptr_q} + (IDX_W+1)'(i);
         if (cand >= NREQ_C) cand = cand - NREQ_C;
         if (!win_found && req_valid[cand[IDX_W-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state_q == S_IDLE && win_found) req_ready[win_idx] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ptr_q       <= IDX_W'(NUM_REQ - 1);
         cnt_q       <= '0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         rsp_valid_q <= '0;
         case (state_q)
            S_IDLE: begin
               if (win_found) begin
                  ptr_q    <= win_idx;
                  pwrite_q <= req_write[win_idx];
                  paddr_q  <= req_addr[win_idx*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
                  pwdata_q <= req_wdata[win_idx*32 +: 32];
                  psel_q   <= 1'b1;
                  state_q  <= S_SETUP;
               end
            end
            S_SETUP: begin
               penable_q <= 1'b1;
               cnt_q     <= '0;
               state_q   <= S_ACCESS;
            end
            S_ACCESS: begin
               if (pready) begin
                  rsp_rdata_q        <= pwrite_q ? 32'h0 : prdata;
                  rsp_err_q          <= pslverr;
                  rsp_valid_q[ptr_q] <= 1'b1;
                  psel_q             <= 1'b0;
                  penable_q          <= 1'b0;
                  state_q            <= S_IDLE;
               end else if (TIMEOUT != 0 && cnt_q == TO_LAST_C) begin
                  // Watchdog expiry completes the transfer as an error.
                  rsp_rdata_q        <= 32'h0;
                  rsp_err_q          <= 1'b1;
                  rsp_valid_q[ptr_q] <= 1'b1;
                  psel_q             <= 1'b0;
                  penable_q          <= 1'b0;
                  state_q            <= S_IDLE;
               end else if (TIMEOUT != 0) begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               psel_q    <= 1'b0;
               penable_q <= 1'b0;
               state_q   <= S_IDLE;
            end
         endcase
      end
   end

   assign psel        = psel_q;
   assign penable     = penable_q;
   assign pwrite      = pwrite_q;
   assign paddr       = paddr_q;
   assign pwdata      = pwdata_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign dbg_state_o = state_q;

endmodule

// File: doc/apb_rr_master.md
# apb_rr_master

Round-robin APB master scheduler that shares one 32-bit APB bus between `NUM_REQ` simple request/response clients, for example the AXI-to-APB bridge command path, a debug port and a DMA-style register loader. It sits directly upstream of the APB slave mux. It arbitrates fairly, sequences the APB SETUP/ACCESS phases and guards every transfer with a `pready` timeout watchdog. Exactly one transfer is in flight at any time.

## Interface
- `NUM_REQ`, default 3: number of requesters, 2..8.
- `APB_ADDR_WIDTH`, default 12: APB address width.
- `TIMEOUT`, default 256: maximum ACCESS cycles without `pready`. 0 disables the watchdog.
- `clk` in 1: clock; all logic is rising-edge.
- `rst` in 1: asynchronous reset, active-high.
- `req_valid` in NUM_REQ: per-requester transfer request.
- `req_ready` out NUM_REQ: one-hot grant/accept pulse.
- `req_write` in NUM_REQ: 1 = write, 0 = read.
- `req_addr` in NUM_REQ×APB_ADDR_WIDTH: packed per-requester address.
- `req_wdata` in NUM_REQ×32: packed per-requester write data.
- `rsp_valid` out NUM_REQ: one-hot, one-cycle completion pulse to the owner.
- `rsp_rdata` out 32: read data; shared and valid with `rsp_valid`.
- `rsp_err` out 1: slave error or timeout; valid with `rsp_valid`.
- `psel`, `penable`, `pwrite` out 1: APB control.
- `paddr` out APB_ADDR_WIDTH: APB address.
- `pwdata` out 32: APB write data.
- `prdata` in 32: APB read data.
- `pready`, `pslverr` in 1: APB completion and error.

## Operation
- States:
  - IDLE: no transfer in progress.
  - SETUP: `psel`=1, `penable`=0, for exactly one cycle.
  - ACCESS: `psel`=1, `penable`=1, until `pready` or timeout.
- IDLE: if any `req_valid` is high, the winner is the first set bit scanning upward from `ptr+1`, modulo NUM_REQ.
  - `req_ready[winner]`=1 combinationally in that cycle.
  - On the clock edge, `req_write`, `req_addr` and `req_wdata` of the winner are registered into `pwrite`, `paddr` and `pwdata`.
  - `ptr` becomes the winner and the state goes to SETUP.
- SETUP always goes to ACCESS.
- ACCESS with `pready`=1:
  - Register `rsp_rdata` = `prdata` for reads, 0 for writes.
  - Register `rsp_err` = `pslverr`.
  - Pulse `rsp_valid[owner]` in the next cycle and return to IDLE.
- ACCESS timeout: `TIMEOUT`≠0 and the ACCESS cycle counter equals `TIMEOUT`-1 with `pready`=0.
  - Treat as complete with `rsp_err`=1 and `rsp_rdata`=0.
  - `psel` and `penable` drop and the state returns to IDLE.
- The counter clears on entry to ACCESS.
- `rsp_valid` has no backpressure. Requesters must accept the pulse.
- IDLE may grant a new request in the same cycle that `rsp_valid` is high.
- A requester may hold `req_valid` high across its own response. It then competes again under round-robin.
- Once `req_ready` is seen, requesters may change request fields freely. Fields are sampled only on the grant edge.
- `pwrite`, `paddr` and `pwdata` hold stable from SETUP through the end of ACCESS.

## Timing
- Reset state: IDLE, `ptr`=NUM_REQ-1 (requester 0 has first priority), counter 0.
- Reset values: `psel`, `penable`, `pwrite`, `paddr`, `pwdata`, `req_ready`, `rsp_valid`, `rsp_rdata`, `rsp_err` all 0.
- Latency with `pready` returned on the first ACCESS cycle:
  - Grant in cycle 0, SETUP in cycle 1, ACCESS in cycle 2.
  - `rsp_valid` in cycle 3, which may coincide with the next grant.
- Peak throughput: one transfer per 3 cycles.
- Each extra wait cycle adds one cycle of latency.
- Timeout: ACCESS lasts exactly `TIMEOUT` cycles, then `rsp_valid` follows in the next cycle.
- Fairness: with all requesters continuously active, grants rotate 0,1,…,NUM_REQ-1,0. No requester waits for more than NUM_REQ-1 other transfers.
- `pready` is ignored outside ACCESS.
- `req_valid` is ignored outside IDLE, and `req_ready` stays 0 there.
- Reset asserted mid-transfer:
  - `psel` and `penable` drop asynchronously.
  - No `rsp_valid` is generated for the aborted transfer.
  - `ptr` returns to NUM_REQ-1.

## Test plan
- Single read: requester 1 reads 0x010 and the slave returns `pready`=1 immediately with `prdata`=0xCAFEF00D.
  - Expect `req_ready`=0b010 in cycle 0.
  - Expect SETUP in cycle 1 and ACCESS in cycle 2 with `paddr`=0x010.
  - Expect `rsp_valid`=0b010 and `rsp_rdata`=0xCAFEF00D in cycle 3.
- Write with 2 wait states and `pslverr`=1: requester 0 writes 0x12345678 to 0x004.
  - Expect `pwdata` held for 3 ACCESS cycles.
  - Expect `rsp_err`=1 and `rsp_rdata`=0.
- Round-robin: all three `req_valid` high continuously for 6 transfers.
  - Expect grant order 0,1,2,0,1,2.
  - Expect back-to-back grants every 3 cycles.
- Timeout: `TIMEOUT`=4 and `pready` held at 0.
  - Expect exactly 4 ACCESS cycles.
  - Then expect `rsp_err`=1 and `rsp_rdata`=0, with the bus idle.
- Reset during ACCESS: assert `rst` mid-wait.
  - Expect `psel`=`penable`=0 immediately and no `rsp_valid`.
  - After reset release, expect requester 0 to win first.
- Late-arriving request: requester 2 raises `req_valid` while requester 0's transfer is in ACCESS.
  - Expect `req_ready` to stay 0 until IDLE.
  - Then expect requester 2 to be granted in the same cycle as requester 0's `rsp_valid`.
